// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the async FIFO
// write port. The arbiter takes the slave view; the requester/FIFO side
// (or a testbench) takes the master view.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [WIDTH-1:0]      wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [15:0]           beat_total;

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, grant_id, busy, beat_total
  );

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, grant_id, busy, beat_total
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for the async FIFO write port (wclk domain).
// A winner holds the port for up to BURST beats, or until it flags its last
// beat or drops valid; one IDLE cycle separates consecutive grants.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input logic               wclk,
  input logic               wrstn,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   pick;
  logic             found;
  logic [CW-1:0]    beat_cnt_q;
  logic [15:0]      beat_total_q;
  logic             gvalid, glast, accept;
  logic [NREQ-1:0]  ready_c;
  logic             winc_c;
  logic [WIDTH-1:0] wdata_c;

  assign gvalid = bus.req_valid[grant_q];
  assign glast  = bus.req_last[grant_q];
  // wfull gates the accept so a full FIFO stalls the beat without losing it
  assign accept = (state_q == GRANT) && gvalid && !bus.wfull;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && bus.req_valid[IDW'(idx)]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // State register: FSM state, current grant and priority pointer
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, release on last/burst limit/drop
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = pick;
        end
      end
      GRANT: begin
        if (!gvalid || (accept && (glast || beat_cnt_q == CW'(BURST - 1)))) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counters: burst count cleared while idle, running total wraps
  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      beat_cnt_q   <= '0;
      beat_total_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        beat_cnt_q <= '0;
      end else if (accept) begin
        beat_cnt_q <= beat_cnt_q + CW'(1);
      end
      if (accept) begin
        beat_total_q <= beat_total_q + 16'd1;
      end
    end
  end

  // Output logic: FIFO write and requester ready, only while granted
  always_comb begin
    ready_c = '0;
    winc_c  = 1'b0;
    wdata_c = '0;
    if (state_q == GRANT) begin
      ready_c[grant_q] = !bus.wfull;
      winc_c           = accept;
      wdata_c          = bus.req_data[int'(grant_q)*WIDTH +: WIDTH];
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.winc       = winc_c;
  assign bus.wdata      = wdata_c;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q == GRANT);
  assign bus.beat_total = beat_total_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus a scoreboard of the
// data the FIFO should receive, and a hand-written mid-burst reset sequence.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic wclk  = 1'b0;
  logic wrstn = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus_if ();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .wclk  (wclk),
    .wrstn (wrstn),
    .bus   (bus_if)
  );

  typedef struct {
    bit         rst;
    logic [3:0] rv;
    logic [3:0] rl;
    logic       wf;
    logic       busy;
    logic [1:0] gid;
    logic       winc;
    logic [3:0] rdy;
    int         bt;
  } row_t;

  row_t       rows[$];
  logic [7:0] exp_q[$];
  int         sent[NREQ];
  int         total = 0;
  int         bad   = 0;

  function automatic void add(bit rst, logic [3:0] rv, logic [3:0] rl, logic wf,
                              logic busy, logic [1:0] gid, logic winc,
                              logic [3:0] rdy, int bt = -1);
    row_t r;
    r = '{rst, rv, rl, wf, busy, gid, winc, rdy, bt};
    rows.push_back(r);
  endfunction

  function automatic void push(logic [7:0] d);
    exp_q.push_back(d);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Requester i presents 0x10 + 32*i + (beats it has had accepted)
  task automatic drive_data();
    for (int i = 0; i < NREQ; i++)
      bus_if.req_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i*32) + 8'(sent[i]);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrstn = 1'b0;
    bus_if.req_valid = '0;
    bus_if.req_last  = '0;
    bus_if.wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    drive_data();
    #1;
    chk("rst_busy",  bus_if.busy, 0);
    chk("rst_winc",  bus_if.winc, 0);
    chk("rst_ready", bus_if.req_ready, 0);
    chk("rst_wdata", bus_if.wdata, 0);
    chk("rst_gid",   bus_if.grant_id, 0);
    chk("rst_total", bus_if.beat_total, 0);
    @(negedge wclk);
    wrstn = 1'b1;
  endtask

  task automatic run_row(row_t r, int n);
    logic [7:0] e;
    if (r.rst) do_reset();
    @(negedge wclk);
    bus_if.req_valid = r.rv;
    bus_if.req_last  = r.rl;
    bus_if.wfull     = r.wf;
    drive_data();
    #1;
    chk($sformatf("row%0d_busy", n),  bus_if.busy, r.busy);
    chk($sformatf("row%0d_gid", n),   bus_if.grant_id, r.gid);
    chk($sformatf("row%0d_winc", n),  bus_if.winc, r.winc);
    chk($sformatf("row%0d_ready", n), bus_if.req_ready, r.rdy);
    chk($sformatf("row%0d_onehot", n), $onehot0(bus_if.req_ready), 1);
    if (r.bt >= 0) chk($sformatf("row%0d_total", n), bus_if.beat_total, r.bt);
    #3;
    // FIFO side: a write lands on the coming edge whenever winc is high now
    if (bus_if.winc) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL row%0d_unexpected_write: got %0h want none", n, bus_if.wdata);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("row%0d_wdata", n), bus_if.wdata, e);
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (bus_if.req_valid[i] && bus_if.req_ready[i]) sent[i]++;
  endtask

  initial begin
    bus_if.req_valid = '0;
    bus_if.req_last  = '0;
    bus_if.wfull     = 1'b0;
    bus_if.req_data  = '0;

    // Single requester 0: two bursts of 4 with one bubble
    add(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0000);
    for (int b = 0; b < 4; b++) add(0, 4'b0001, 0, 0, 1, 0, 1, 4'b0001);
    add(0, 4'b0001, 0, 0, 0, 0, 0, 4'b0000);
    for (int b = 0; b < 4; b++) add(0, 4'b0001, 0, 0, 1, 0, 1, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 8);
    for (int d = 0; d < 8; d++) push(8'h10 + 8'(d));

    // All four valid: rotation 0,1,2,3,0 then drop valid mid-burst
    for (int g = 0; g < 4; g++) begin
      add(g == 0, 4'b1111, 0, 0, 0, (g == 0) ? 2'd0 : 2'(g - 1), 0, 4'b0000);
      for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 0, 1, 2'(g), 1, 4'(1 << g));
    end
    add(0, 4'b1111, 0, 0, 0, 3, 0, 4'b0000);
    add(0, 4'b1111, 0, 0, 1, 0, 1, 4'b0001);
    add(0, 4'b0000, 0, 0, 1, 0, 0, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 17);
    for (int g = 0; g < 4; g++)
      for (int d = 0; d < 4; d++) push(8'h10 + 8'(g*32) + 8'(d));
    push(8'h14);

    // Requester 2 stalled by wfull for 5 cycles at beat 2
    add(1, 4'b0100, 0, 0, 0, 0, 0, 4'b0000);
    for (int b = 0; b < 2; b++) add(0, 4'b0100, 0, 0, 1, 2, 1, 4'b0100);
    for (int s = 0; s < 5; s++) add(0, 4'b0100, 0, 1, 1, 2, 0, 4'b0000);
    for (int b = 0; b < 2; b++) add(0, 4'b0100, 0, 0, 1, 2, 1, 4'b0100);
    add(0, 4'b0000, 0, 0, 0, 2, 0, 4'b0000, 4);
    for (int d = 0; d < 4; d++) push(8'h50 + 8'(d));

    // Requester 1 ends its burst with req_last on beat 2; rotation continues
    add(1, 4'b0010, 0,       0, 0, 0, 0, 4'b0000);
    add(0, 4'b0110, 0,       0, 1, 1, 1, 4'b0010);
    add(0, 4'b0110, 4'b0010, 0, 1, 1, 1, 4'b0010);
    add(0, 4'b0111, 0,       0, 0, 1, 0, 4'b0000);
    add(0, 4'b0111, 0,       0, 1, 2, 1, 4'b0100);
    add(0, 4'b0000, 0,       0, 1, 2, 0, 4'b0100);
    add(0, 4'b0101, 0,       0, 0, 2, 0, 4'b0000);
    add(0, 4'b0101, 0,       0, 1, 0, 1, 4'b0001);
    add(0, 4'b0000, 0,       0, 1, 0, 0, 4'b0001);
    add(0, 4'b0000, 0,       0, 0, 0, 0, 4'b0000, 4);
    push(8'h30); push(8'h31); push(8'h50); push(8'h10);

    // Requester 1 drops valid in its first grant cycle; pointer moves to 1
    add(1, 4'b0010, 0, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0000, 0, 0, 1, 1, 0, 4'b0010);
    add(0, 4'b0110, 0, 0, 0, 1, 0, 4'b0000);
    add(0, 4'b0110, 0, 0, 1, 2, 1, 4'b0100);
    add(0, 4'b0000, 0, 0, 1, 2, 0, 4'b0100);
    add(0, 4'b0000, 0, 0, 0, 2, 0, 4'b0000, 1);
    push(8'h50);

    foreach (rows[i]) run_row(rows[i], i);
    rows.delete();

    // Reset asserted during the third beat of a burst from requester 0
    push(8'h10); push(8'h11);
    add(1, 4'b0001, 0, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b0001, 0, 0, 1, 0, 1, 4'b0001);
    add(0, 4'b0001, 0, 0, 1, 0, 1, 4'b0001);
    foreach (rows[i]) run_row(rows[i], 100 + i);
    rows.delete();

    @(negedge wclk);
    drive_data();
    #1;
    chk("mid_winc_before", bus_if.winc, 1);
    chk("mid_wdata_before", bus_if.wdata, 8'h12);
    #1 wrstn = 1'b0;
    #1;
    chk("mid_winc",  bus_if.winc, 0);
    chk("mid_busy",  bus_if.busy, 0);
    chk("mid_ready", bus_if.req_ready, 0);
    chk("mid_total", bus_if.beat_total, 0);
    chk("mid_wdata", bus_if.wdata, 0);
    @(posedge wclk);
    #1;
    chk("mid_total_edge", bus_if.beat_total, 0);
    chk("mid_winc_edge",  bus_if.winc, 0);
    @(negedge wclk);
    bus_if.req_valid = '0;
    for (int i = 0; i < NREQ; i++) sent[i] = 0;
    drive_data();
    wrstn = 1'b1;

    push(8'h10);
    add(0, 4'b1111, 0, 0, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 0, 0, 1, 0, 1, 4'b0001);
    add(0, 4'b0000, 0, 0, 1, 0, 0, 4'b0001);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 1);
    foreach (rows[i]) run_row(rows[i], 200 + i);

    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the team's asynchronous FIFO among NREQ requesters in the wclk domain. It runs round-robin arbitration with bounded bursts and holds a grant for up to BURST beats. It drives the FIFO's winc/wdata and back-pressures requesters from the FIFO's wfull. It sits between the requester valid/ready interfaces and the FIFO's write-domain inputs.

## Interface
- NREQ, 4: number of requesters; at least 2.
- WIDTH, 8: data width; must match the FIFO WIDTH.
- BURST, 4: maximum beats per grant; at least 1.
- IDW, $clog2(NREQ): width of the grant index.
- wclk  in  1  write-domain clock; all logic is on its rising edge.
- wrstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  bit i means requester i offers a beat.
- req_data  in  NREQ*WIDTH  slice [i*WIDTH +: WIDTH] is requester i's data.
- req_last  in  NREQ  bit i marks requester i's final beat of a burst.
- req_ready  out  NREQ  one-hot or zero; bit i means the beat from requester i is accepted this cycle.
- wfull  in  1  FIFO full flag.
- winc  out  1  FIFO write enable.
- wdata  out  WIDTH  FIFO write data.
- grant_id  out  IDW  current or last granted requester index.
- busy  out  1  high while the FSM is in GRANT.
- beat_total  out  16  count of beats written to the FIFO since reset; wraps at 0xFFFF→0.

## Operation
- FSM has two states: IDLE and GRANT. Reset state is IDLE.
- Priority pointer last_gnt resets to NREQ-1, so requester 0 has top priority first.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching last_gnt+1, last_gnt+2, … modulo NREQ.
  - Register the selection in grant_id, clear beat_cnt, and move to GRANT.
  - If no req_valid bit is set, stay in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !wfull. All other req_ready bits are 0.
  - A beat is accepted when req_valid[g] && req_ready[g].
  - winc = accepted beat. wdata = req_data slice g whenever the FSM is in GRANT, otherwise 0.
  - On each accept, beat_cnt increments (width $clog2(BURST+1)) and beat_total increments.
  - Leave GRANT for IDLE and set last_gnt ← g when any of these holds:
    - a beat is accepted with req_last[g] = 1;
    - a beat is accepted with beat_cnt == BURST-1;
    - req_valid[g] = 0 (voluntary release; no beat that cycle).
  - While wfull = 1 and req_valid[g] = 1, hold GRANT indefinitely. No timeout and no beat loss.
- Requests from non-granted requesters are ignored until the next IDLE cycle. They must hold req_valid; the arbiter stores nothing for them.
- winc is never asserted while wfull = 1. winc is never asserted in IDLE.
- req_valid is sampled only; the block never modifies requester data.

## Timing
- Reset values:
  - state IDLE; grant_id 0; last_gnt NREQ-1; beat_cnt 0; beat_total 0.
  - Outputs busy, winc and req_ready are all 0; wdata is 0.
- Arbitration latency:
  - Request seen in IDLE at cycle N → busy = 1 and grant_id valid at cycle N+1.
  - The first beat can be written in cycle N+1 if wfull = 0.
- Throughput: one beat per cycle inside a burst, then exactly one IDLE (bubble) cycle between bursts. Maximum utilisation is BURST/(BURST+1).
- winc, req_ready and wdata are combinational from state, grant_id, req_valid and wfull. wfull comes from the FIFO's own wclk-domain flop, so the path has no loop through registers.
- Assertion of wrstn mid-burst:
  - All state clears immediately (asynchronously) and winc drops in the same instant.
  - A beat on the wclk edge coinciding with reset is not written.
- wfull rising in the same cycle as a would-be beat: no accept, no winc, beat_cnt unchanged.

## Test plan
- Single requester, NREQ=4, BURST=4: req_valid=0001 held, data 0x10..0x17, wfull=0.
  - Required: two bursts of 4 winc pulses separated by one idle cycle.
  - FIFO receives 0x10–0x17 in order; beat_total = 8.
- All four requesters valid continuously:
  - Grant order 0,1,2,3,0,…; each holds for 4 beats.
  - req_ready stays one-hot or zero throughout.
- Requester 2 granted, wfull forced to 1 for 5 cycles at beat 2:
  - winc = 0 and req_ready = 0 for those 5 cycles; grant stays on 2.
  - Beat 2 data is written on the first cycle after wfull falls; no duplicate, no loss.
- Requester 1 asserts req_last on beat 2 (BURST=4):
  - Grant releases after 2 beats; next grant goes to requester 2 if valid, otherwise to 3, 0, or back to 1.
- Granted requester drops req_valid in its first GRANT cycle:
  - No winc; the FSM returns to IDLE; last_gnt = that requester.
- wrstn pulsed low during beat 3 of a burst:
  - winc, busy and req_ready go to 0 at once; beat_total = 0.
  - After release, requester 0 wins first arbitration.
